// File: rtl/boruss_debug_trace_tx.sv
// Debug trace transmitter: snapshots boruss_cpu state on WRITEBACK and on HALT entry,
// queues snapshots in a small FIFO and streams each one as an 8-byte UART 8N1 frame.
module boruss_debug_trace_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [2:0] cpu_state,
  input  logic [7:0] pc,
  input  logic [7:0] reg_a,
  input  logic [7:0] reg_b,
  input  logic [7:0] reg_c,
  input  logic [7:0] reg_d,
  output logic       tx,
  output logic       busy,
  output logic [7:0] overflow_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [2:0]    ST_WRITEBACK = 3'b011;
  localparam logic [2:0]    ST_HALT      = 3'b101;
  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

  logic [47:0]   fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q, count_d;
  logic          haltSeen_q;
  logic [7:0]    ovf_q;

  txState_e      state_q;
  logic [CW-1:0] clkCnt_q;
  logic [2:0]    bitIdx_q;
  logic [2:0]    byteIdx_q;
  logic [47:0]   snap_q;
  logic          tx_q;
  logic          busy_q;

  logic        capture, fifoEmpty, fifoFull, bitEnd, frameEnd, pop, push, goIdle;
  logic [7:0]  curByte, chkByte;
  logic [47:0] newSnap;

  assign capture   = sample_en & ((cpu_state == ST_WRITEBACK) |
                                  ((cpu_state == ST_HALT) & ~haltSeen_q));
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == DEPTH_CNT);
  assign bitEnd    = (clkCnt_q == BIT_LAST);
  assign frameEnd  = (state_q == STOP) & bitEnd & (byteIdx_q == 3'd7);
  // A frame ending on this edge frees a slot, so a capture into a full FIFO is still accepted.
  assign pop       = ~fifoEmpty & ((state_q == IDLE) | frameEnd);
  assign push      = capture & (~fifoFull | pop);
  assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign goIdle    = ((state_q == IDLE) | frameEnd) & ~pop;
  assign newSnap   = {pc, 5'b00000, cpu_state, reg_a, reg_b, reg_c, reg_d};

  always_comb begin
    chkByte = snap_q[47:40] ^ snap_q[39:32] ^ snap_q[31:24] ^
              snap_q[23:16] ^ snap_q[15:8]  ^ snap_q[7:0];
    curByte = 8'hA5;
    case (byteIdx_q)
      3'd0:    curByte = 8'hA5;
      3'd1:    curByte = snap_q[47:40];
      3'd2:    curByte = snap_q[39:32];
      3'd3:    curByte = snap_q[31:24];
      3'd4:    curByte = snap_q[23:16];
      3'd5:    curByte = snap_q[15:8];
      3'd6:    curByte = snap_q[7:0];
      default: curByte = chkByte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= newSnap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      haltSeen_q <= 1'b0;
      ovf_q      <= 8'h00;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
      if (sample_en) haltSeen_q <= (cpu_state == ST_HALT);
      if (capture & ~push & (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'h01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clkCnt_q  <= '0;
      bitIdx_q  <= '0;
      byteIdx_q <= '0;
      snap_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= ~goIdle | (count_d != '0);
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= START;
            snap_q    <= fifoMem_q[rdPtr_q];
            byteIdx_q <= 3'd0;
            clkCnt_q  <= '0;
            tx_q      <= 1'b0;
          end
        end
        START: begin
          if (bitEnd) begin
            state_q  <= DATA;
            clkCnt_q <= '0;
            bitIdx_q <= 3'd0;
            tx_q     <= curByte[0];
          end else begin
            clkCnt_q <= clkCnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bitEnd) begin
            clkCnt_q <= '0;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              tx_q     <= curByte[bitIdx_q + 3'd1];
            end
          end else begin
            clkCnt_q <= clkCnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bitEnd) begin
            clkCnt_q <= '0;
            if (byteIdx_q != 3'd7) begin
              state_q   <= START;
              byteIdx_q <= byteIdx_q + 3'd1;
              tx_q      <= 1'b0;
            end else if (pop) begin
              state_q   <= START;
              snap_q    <= fifoMem_q[rdPtr_q];
              byteIdx_q <= 3'd0;
              tx_q      <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            clkCnt_q <= clkCnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx             = tx_q;
  assign busy           = busy_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_boruss_debug_trace_tx.sv
// Self-checking bench for boruss_debug_trace_tx: a frame-level reference model predicts
// line timing and busy/overflow, and a UART decoder feeds a byte scoreboard.
module tb_boruss_debug_trace_tx;

  localparam int CPB        = 4;
  localparam int DEPTH      = 4;
  localparam int FRAME_CLKS = 80 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [2:0] cpu_state = 3'd0;
  logic [7:0] pc = 8'd0, reg_a = 8'd0, reg_b = 8'd0, reg_c = 8'd0, reg_d = 8'd0;
  logic       tx, busy;
  logic [7:0] overflow_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: pending snapshots, expected byte stream, frame in flight.
  logic [47:0] mq[$];
  logic [7:0]  expBytes[$];
  int          frameLeft = 0;
  logic [79:0] curBits = '1;
  logic [7:0]  mOvf = 8'd0;
  logic        mHalt = 1'b0;
  logic        mCap, mPop;

  // UART decoder state
  logic       dActive = 1'b0;
  int         dCnt = 0;
  int         dBit = 0;
  logic [7:0] dByte = 8'd0;

  always #5 clk = ~clk;

  boruss_debug_trace_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .cpu_state(cpu_state),
    .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
    .tx(tx), .busy(busy), .overflow_count(overflow_count)
  );

  function automatic logic [7:0] frameByte(input logic [47:0] s, input int k);
    logic [7:0] chk;
    chk = 8'h00;
    for (int i = 0; i < 6; i++) chk ^= s[8*i +: 8];
    if (k == 0) return 8'hA5;
    if (k == 7) return chk;
    return s[47 - 8*(k-1) -: 8];
  endfunction

  function automatic logic [79:0] buildBits(input logic [47:0] s);
    logic [79:0] bits;
    logic [7:0]  b;
    for (int k = 0; k < 8; k++) begin
      b = frameByte(s, k);
      bits[10*k] = 1'b0;
      for (int i = 0; i < 8; i++) bits[10*k + 1 + i] = b[i];
      bits[10*k + 9] = 1'b1;
    end
    return bits;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s at %0t: got event/timeout, expected none", name, $time);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      expBytes.delete();
      frameLeft = 0;
      curBits   = '1;
      mOvf      = 8'd0;
      mHalt     = 1'b0;
    end else begin
      mCap = 1'b0;
      if (sample_en) begin
        if (cpu_state == 3'b011) mCap = 1'b1;
        if (cpu_state == 3'b101 && !mHalt) begin
          mCap  = 1'b1;
          mHalt = 1'b1;
        end
        if (cpu_state != 3'b101) mHalt = 1'b0;
      end
      if (frameLeft > 0) frameLeft--;
      mPop = (frameLeft == 0) && (mq.size() > 0);
      if (mCap) begin
        if (mq.size() < DEPTH || mPop) begin
          mq.push_back({pc, 5'b00000, cpu_state, reg_a, reg_b, reg_c, reg_d});
          for (int k = 0; k < 8; k++)
            expBytes.push_back(frameByte({pc, 5'b00000, cpu_state, reg_a, reg_b, reg_c, reg_d}, k));
        end else if (mOvf != 8'hFF) begin
          mOvf++;
        end
      end
      if (mPop) begin
        curBits   = buildBits(mq.pop_front());
        frameLeft = FRAME_CLKS;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("tx_line", tx, (frameLeft == 0) ? 1 : curBits[(FRAME_CLKS - frameLeft) / CPB]);
    checkOutput("busy", busy, (frameLeft > 0 || mq.size() > 0) ? 1 : 0);
    checkOutput("overflow_count", overflow_count, mOvf);
  end

  always @(negedge clk) begin
    if (reset) begin
      dActive = 1'b0;
    end else if (!dActive) begin
      if (tx === 1'b0) begin
        dActive = 1'b1;
        dCnt    = 0;
      end
    end else begin
      dCnt++;
      if (dCnt % CPB == CPB / 2) begin
        dBit = dCnt / CPB;
        if (dBit == 0) checkOutput("start_bit", tx, 0);
        else if (dBit <= 8) dByte[dBit-1] = tx;
        else begin
          checkOutput("stop_bit", tx, 1);
          if (expBytes.size() == 0) failNow("unexpected_byte");
          else checkOutput("frame_byte", dByte, expBytes.pop_front());
          dActive = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic se, input logic [2:0] st, input logic [7:0] p,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    #1;
    sample_en = se;
    cpu_state = st;
    pc = p; reg_a = a; reg_b = b; reg_c = c; reg_d = d;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom));
  endtask

  task automatic randCapture(input logic [2:0] st);
    applyStimulus(1'b1, st, 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom));
  endtask

  task automatic waitIdle(input int limit, input string name);
    int n;
    n = 0;
    while ((frameLeft > 0 || mq.size() > 0) && n < limit) begin
      idleCycle();
      n++;
    end
    if (frameLeft > 0 || mq.size() > 0) failNow(name);
    repeat (4) idleCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic [7:0] savedOvf;

    // Reset held: captures must be ignored.
    repeat (2) idleCycle();
    applyStimulus(1'b1, 3'b011, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    idleCycle();
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ovf", overflow_count, 0);
    reset = 1'b0;
    repeat (30) idleCycle();

    // Single frame with directed values, latency and frame length.
    applyStimulus(1'b1, 3'b011, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
    idleCycle();
    checkOutput("latency_capture_edge", tx, 1);
    idleCycle();
    checkOutput("latency_start_bit", tx, 0);
    k = 0;
    while (busy === 1'b1 && k < 1000) begin
      idleCycle();
      k++;
    end
    checkOutput("frame_length", k, FRAME_CLKS);
    waitIdle(2000, "single_frame_timeout");

    // Filtering: non-capturing states, then HALT held across three pulses.
    for (int s = 0; s < 8; s++) begin
      if (s != 3 && s != 5) begin
        randCapture(3'(s));
        idleCycle();
      end
    end
    repeat (3) begin
      randCapture(3'b101);
      repeat (3) idleCycle();
    end
    waitIdle(2000, "halt_frame_timeout");

    // Overflow: six back-to-back captures, then saturation.
    for (int i = 0; i < 6; i++) randCapture(3'b011);
    idleCycle();
    checkOutput("ovf_after_six", overflow_count, 1);
    for (int i = 0; i < 300; i++) randCapture(3'b011);
    idleCycle();
    checkOutput("ovf_saturated", overflow_count, 8'hFF);
    waitIdle(3000, "overflow_drain_timeout");

    // Reset during data bit 3 of byte 2.
    randCapture(3'b011);
    repeat (99) idleCycle();
    #1 reset = 1'b1;
    #1;
    checkOutput("midframe_reset_tx", tx, 1);
    checkOutput("midframe_reset_busy", busy, 0);
    checkOutput("midframe_reset_ovf", overflow_count, 0);
    repeat (3) idleCycle();
    reset = 1'b0;
    repeat (10) idleCycle();
    randCapture(3'b011);
    waitIdle(2000, "post_reset_frame_timeout");

    // Capture while full on the pop edge is accepted.
    for (int i = 0; i < 6; i++) randCapture(3'b011);
    k = 0;
    while (frameLeft != 1 && k < 2000) begin
      idleCycle();
      k++;
    end
    if (frameLeft != 1) failNow("pop_edge_align_timeout");
    savedOvf = mOvf;
    randCapture(3'b011);
    idleCycle();
    checkOutput("ovf_push_on_pop", overflow_count, savedOvf);
    randCapture(3'b011);
    idleCycle();
    checkOutput("ovf_push_after_pop", overflow_count, savedOvf + 8'd1);
    waitIdle(3000, "push_on_pop_drain_timeout");

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       randCapture(3'b011);
          1:       randCapture(3'b101);
          default: randCapture(3'($urandom));
        endcase
      end else begin
        idleCycle();
      end
    end
    waitIdle(3000, "random_drain_timeout");
    checkOutput("scoreboard_drained", expBytes.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
